// File: rtl/tube_disp_sched.sv
// tube_disp_sched: shares the 4-digit tube driver between a background
// value and two prioritised, acked display requesters with a fixed hold.
module tube_disp_sched #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int HOLD_MS  = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bg_data,
    input  logic        req0,
    input  logic [15:0] data0,
    output logic        ack0,
    input  logic        req1,
    input  logic [15:0] data1,
    output logic        ack1,
    output logic [3:0]  d0,
    output logic [3:0]  d1,
    output logic [3:0]  d2,
    output logic [3:0]  d3,
    output logic [1:0]  src
);

    localparam int          MS        = CLK_FREQ / 1000;
    localparam logic [15:0] MS_LAST   = 16'(MS - 1);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_MS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHOW0 = 2'b01,
        SHOW1 = 2'b10
    } state_t;

    state_t      state, state_nx;
    logic [15:0] ms_cnt, ms_nx;
    logic [15:0] hold_cnt, hold_nx;
    logic [15:0] disp_reg, disp_nx;
    logic [15:0] dout, dout_nx;
    logic        ack0_nx, ack1_nx;
    logic        busy, acc0, acc1, tick;

    // Arbitration, hold timing and next display value.
    always_comb begin
        busy     = ack0 | ack1;
        acc0     = req0 & ~busy;
        acc1     = req1 & ~busy & ~req0 & (state != SHOW0);
        tick     = (ms_cnt == MS_LAST);
        state_nx = state;
        hold_nx  = hold_cnt;
        disp_nx  = disp_reg;
        ms_nx    = tick ? 16'd0 : ms_cnt + 16'd1;
        ack0_nx  = 1'b0;
        ack1_nx  = 1'b0;
        unique case (1'b1)
            acc0: begin
                state_nx = SHOW0;
                disp_nx  = data0;
                hold_nx  = HOLD_INIT;
                ms_nx    = 16'd0;
                ack0_nx  = 1'b1;
            end
            acc1: begin
                state_nx = SHOW1;
                disp_nx  = data1;
                hold_nx  = HOLD_INIT;
                ms_nx    = 16'd0;
                ack1_nx  = 1'b1;
            end
            default: begin
                if (state != IDLE && tick) begin
                    if (hold_cnt == 16'd0) state_nx = IDLE;
                    else hold_nx = hold_cnt - 16'd1;
                end
            end
        endcase
        if (acc0 | acc1)         dout_nx = disp_nx;
        else if (state == IDLE)  dout_nx = bg_data;
        else                     dout_nx = disp_reg;
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            ms_cnt   <= 16'd0;
            hold_cnt <= 16'd0;
            disp_reg <= 16'd0;
            dout     <= 16'd0;
            ack0     <= 1'b0;
            ack1     <= 1'b0;
        end else begin
            state    <= state_nx;
            ms_cnt   <= ms_nx;
            hold_cnt <= hold_nx;
            disp_reg <= disp_nx;
            dout     <= dout_nx;
            ack0     <= ack0_nx;
            ack1     <= ack1_nx;
        end
    end

    assign src = state;
    assign d0  = dout[3:0];
    assign d1  = dout[7:4];
    assign d2  = dout[11:8];
    assign d3  = dout[15:12];

endmodule

// File: tb/tb_tube_disp_sched.sv
// tb_tube_disp_sched: scoreboard bench with a cycle-count owner model
// for the display scheduler.
module tb_tube_disp_sched;

    localparam int HOLD_CYC = 30;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bg_data = 16'h0000;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic [15:0] data0 = 16'h0000, data1 = 16'h0000;
    logic        ack0, ack1;
    logic [3:0]  d0, d1, d2, d3;
    logic [1:0]  src;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct packed {
        logic        a0;
        logic        a1;
        logic [1:0]  own;
        logic [15:0] d;
    } exp_t;

    exp_t exp_q[$];

    tube_disp_sched #(.CLK_FREQ(10_000), .HOLD_MS(3)) dut (
        .clk(clk), .rst_n(rst_n), .bg_data(bg_data),
        .req0(req0), .data0(data0), .ack0(ack0),
        .req1(req1), .data1(data1), .ack1(ack1),
        .d0(d0), .d1(d1), .d2(d2), .d3(d3), .src(src)
    );

    always #5 clk = ~clk;

    // Reference model: owner plus absolute expiry cycle.
    int          cyc = 0;
    int          m_exp = 0;
    logic [1:0]  m_own = 2'd0;
    logic        m_a0 = 1'b0, m_a1 = 1'b0;
    logic [15:0] m_disp = 16'h0, m_d = 16'h0;

    always @(posedge clk) begin
        logic blk, a0, a1;
        logic [15:0] nd;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_own = 0; m_a0 = 0; m_a1 = 0; m_d = 0; m_disp = 0;
        end else begin
            blk = m_a0 | m_a1;
            a0 = req0 & !blk;
            a1 = req1 & !blk & !a0 & (m_own != 2'd1);
            if (a0) nd = data0;
            else if (a1) nd = data1;
            else if (m_own == 2'd0) nd = bg_data;
            else nd = m_disp;
            if (a0) begin
                m_own = 2'd1; m_disp = data0; m_exp = cyc + HOLD_CYC;
            end else if (a1) begin
                m_own = 2'd2; m_disp = data1; m_exp = cyc + HOLD_CYC;
            end else if (m_own != 2'd0 && cyc == m_exp) begin
                m_own = 2'd0;
            end
            m_a0 = a0; m_a1 = a1; m_d = nd;
        end
        exp_q.push_back('{m_a0, m_a1, m_own, m_d});
    end

    // Monitor: compare DUT outputs against the queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks = n_checks + 3;
            if ({ack0, ack1} !== {e.a0, e.a1}) begin
                n_fail = n_fail + 1;
                $display("FAIL ack t=%0t got %b%b want %b%b",
                         $time, ack0, ack1, e.a0, e.a1);
            end
            if (src !== e.own) begin
                n_fail = n_fail + 1;
                $display("FAIL src t=%0t got %b want %b",
                         $time, src, e.own);
            end
            if ({d3, d2, d1, d0} !== e.d) begin
                n_fail = n_fail + 1;
                $display("FAIL digits t=%0t got %h want %h",
                         $time, {d3, d2, d1, d0}, e.d);
            end
        end
    end

    // One cycle of requester behaviour: drop req after its ack.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
    endtask

    initial begin
        logic p0, p1;
        rst_n = 1'b0;
        bg_data = 16'h1234;
        step(3);
        rst_n = 1'b1;
        step(6);
        data0 = 16'hABCD; req0 = 1'b1;
        step(40);
        data1 = 16'h5555; req1 = 1'b1;
        step(10);
        data0 = 16'h9999; req0 = 1'b1;
        step(40);
        data0 = 16'h1111; req0 = 1'b1;
        data1 = 16'h2222; req1 = 1'b1;
        step(20);
        data0 = 16'h7777; req0 = 1'b1;
        step(80);
        data1 = 16'h3333; req1 = 1'b1;
        step(10);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(10);
        for (int i = 0; i < 4000; i++) begin
            p0 = req0;
            p1 = req1;
            step(1);
            if ($urandom_range(0, 15) == 0) bg_data = 16'($urandom);
            if ($urandom_range(0, 599) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
            if (req0 && !ack0 && $urandom_range(0, 60) == 0) req0 = 1'b0;
            if (req1 && !ack1 && $urandom_range(0, 60) == 0) req1 = 1'b0;
            if (!p0 && !req0 && $urandom_range(0, 49) == 0) begin
                data0 = 16'($urandom); req0 = 1'b1;
            end
            if (!p1 && !req1 && $urandom_range(0, 29) == 0) begin
                data1 = 16'($urandom); req1 = 1'b1;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        step(3);
        @(negedge clk);
        #1;
        n_checks = n_checks + 1;
        if (exp_q.size() > 1) begin
            n_fail = n_fail + 1;
            $display("FAIL drain got %0d left want <=1", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
